// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage.
//   common : scalar aliases and the default reset PC.
//   pipes  : fetch/decode payload struct and the fetch FSM state enum.
package common;
   typedef logic        u1;
   typedef logic [31:0] u32;
   typedef logic [63:0] u64;

   // Must agree with the reset PC of the fetch/decode register.
   localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;
endpackage

package pipes;
   import common::*;

   typedef struct packed {
      u64 pc;
      u32 instruction;
   } fetch_data_t;

   // BUSY: request outstanding for pc
   // DROP: request outstanding, its data is stale and will be discarded
   // WAIT: no request, output slot is blocked
   // FULL: skid buffer holds an instruction behind the stalled slot
   typedef enum logic [1:0] {BUSY, DROP, WAIT, FULL} fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, issues one
// instruction-bus request at a time, presents fetched instructions to the
// fetch/decode register, absorbs a downstream stall with a one-entry skid
// buffer and discards in-flight fetches on a redirect.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   ireq_valid/addr   : bus request, held stable until iresp_data_ok
//   iresp_data_ok/data: one-cycle response completing the request
//   stall             : downstream cannot take dataF this cycle
//   redirect_valid/pc : one-cycle PC redirect, target bits [1:0] ignored
//   dataF, validF     : output slot {pc, instruction} and its valid flag
module fetch_stage
   import common::*;
   import pipes::*;
#(
   parameter u64 PC_RESET = PC_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output fetch_data_t dataF,
   output logic        validF
);

   fetch_state_t state_q, state_d;
   u64           pc_q, pc_d;
   u64           req_addr_q, req_addr_d;
   fetch_data_t  slot_q, slot_d;
   u1            slot_valid_q, slot_valid_d;
   u64           skid_pc_q, skid_pc_d;
   u32           skid_instr_q, skid_instr_d;
   u1            skid_valid_q, skid_valid_d;

   u1 slot_drain;
   u1 slot_free;
   u1 req_out;

   assign slot_drain = slot_valid_q && !stall;
   assign slot_free  = !slot_valid_q || !stall;
   assign req_out    = (state_q == BUSY) || (state_q == DROP);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BUSY;
         pc_q         <= PC_RESET;
         req_addr_q   <= PC_RESET;
         slot_q       <= '{pc: PC_RESET, instruction: 32'h0};
         slot_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         slot_q       <= slot_d;
         slot_valid_q <= slot_valid_d;
         skid_valid_q <= skid_valid_d;
      end
      // Skid payload is only meaningful while skid_valid_q is set.
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         // A request still in flight must be allowed to finish on the bus.
         state_d = (req_out && !iresp_data_ok) ? DROP : BUSY;
      end else begin
         case (state_q)
            BUSY: if (iresp_data_ok) begin
               // A stall seen now is taken as a stall next cycle as well, so
               // stop fetching rather than risk a second word with nowhere to go.
               if (slot_free) state_d = stall ? WAIT : BUSY;
               else           state_d = FULL;
            end
            DROP: if (iresp_data_ok) state_d = BUSY;
            WAIT: if (slot_free)     state_d = BUSY;
            FULL: if (slot_drain)    state_d = BUSY;
            default: state_d = BUSY;
         endcase
      end
   end

   // Datapath / output-slot logic
   always_comb begin
      pc_d         = pc_q;
      slot_d       = slot_q;
      slot_valid_d = slot_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_valid_d = skid_valid_q;

      if (redirect_valid) begin
         pc_d         = redirect_pc & ~64'h3;
         slot_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (slot_drain) slot_valid_d = 1'b0;
         case (state_q)
            BUSY: if (iresp_data_ok) begin
               pc_d = req_addr_q + 64'd4;
               if (slot_free) begin
                  slot_d       = '{pc: req_addr_q, instruction: iresp_data};
                  slot_valid_d = 1'b1;
               end else begin
                  skid_pc_d    = req_addr_q;
                  skid_instr_d = iresp_data;
                  skid_valid_d = 1'b1;
               end
            end
            FULL: if (slot_drain) begin
               slot_d       = '{pc: skid_pc_q, instruction: skid_instr_q};
               slot_valid_d = 1'b1;
               skid_valid_d = 1'b0;
            end
            default: ;
         endcase
      end

      // A new request is issued whenever the next state is BUSY; in DROP the
      // old address stays on the bus until its data_ok arrives.
      req_addr_d = (state_d == BUSY) ? pc_d : req_addr_q;
   end

   // Outputs
   always_comb begin
      ireq_valid = req_out && !reset;
      ireq_addr  = req_addr_q;
      dataF      = slot_q;
      validF     = slot_valid_q;
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   import common::*;
   import pipes::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok = 1'b0;
   logic [31:0] iresp_data = 32'h0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   fetch_data_t dataF;
   logic        validF;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .dataF         (dataF),
      .validF        (validF)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus model: answers each request after lat cycles (lat=1 -> same cycle).
   int lat  = 1;
   int bcnt = 0;
   always @(posedge clk) begin
      #2;
      if (ireq_valid) begin
         if (bcnt + 1 >= lat) begin
            iresp_data_ok = 1'b1;
            iresp_data    = instr_of(ireq_addr);
            bcnt          = 0;
         end else begin
            iresp_data_ok = 1'b0;
            bcnt++;
         end
      end else begin
         iresp_data_ok = 1'b0;
         bcnt          = 0;
      end
   end

   // Reference model: an output queue (front = visible slot, at most one
   // entry behind it), the next fetch address, and the one outstanding
   // request with a flag saying whether its data is still wanted.
   fetch_data_t mq[$];
   logic [63:0] m_fpc, m_raddr;
   bit          m_live, m_drop, m_drained;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_fpc   = PC_RESET_DEFAULT;
         m_raddr = PC_RESET_DEFAULT;
         m_live  = 1'b1;
         m_drop  = 1'b0;
      end else begin
         m_drained = (mq.size() > 0) && !stall;
         if (m_drained) void'(mq.pop_front());
         if (redirect_valid) begin
            m_fpc = redirect_pc & ~64'h3;
            mq.delete();
            if (m_live && !iresp_data_ok) begin
               m_drop = 1'b1;
            end else begin
               m_live  = 1'b1;
               m_drop  = 1'b0;
               m_raddr = m_fpc;
            end
         end else if (m_live && iresp_data_ok) begin
            if (m_drop) begin
               m_drop  = 1'b0;
               m_raddr = m_fpc;
            end else begin
               mq.push_back('{pc: m_raddr, instruction: iresp_data});
               m_fpc   = m_raddr + 64'd4;
               m_live  = !stall;
               m_raddr = m_fpc;
            end
         end else if (!m_live && m_drained) begin
            m_live  = 1'b1;
            m_raddr = m_fpc;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_ireq_valid", {63'h0, ireq_valid}, {63'h0, (m_live && !reset)});
         if (m_live && !reset) check("m_ireq_addr", ireq_addr, m_raddr);
         check("m_validF", {63'h0, validF}, {63'h0, (mq.size() > 0)});
         if (mq.size() > 0) begin
            check("m_dataF_pc", dataF.pc, mq[0].pc);
            check("m_dataF_instr", {32'h0, dataF.instruction}, {32'h0, mq[0].instruction});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   // Leaves the caller at the first cycle after reset release (inputs phase).
   task automatic do_reset(input int l);
      step();
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; lat = l;
      step();
      cmp_en = 1'b1;
      look();
      check("rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
      check("rst_validF", {63'h0, validF}, 64'h0);
      check("rst_dataF_pc", dataF.pc, 64'h8000_0000);
      check("rst_dataF_instr", {32'h0, dataF.instruction}, 64'h0);
      step();
      reset = 1'b0;
   endtask

   logic [23:0] stall_pat;
   bit          found;

   initial begin
      // 1-cycle bus, back-to-back fetches
      do_reset(1);
      look();
      check("s1_c1_ireq_valid", {63'h0, ireq_valid}, 64'h1);
      check("s1_c1_addr", ireq_addr, 64'h8000_0000);
      check("s1_c1_validF", {63'h0, validF}, 64'h0);
      step(); look();
      check("s1_c2_addr", ireq_addr, 64'h8000_0004);
      check("s1_c2_validF", {63'h0, validF}, 64'h1);
      check("s1_c2_pc", dataF.pc, 64'h8000_0000);
      check("s1_c2_instr", {32'h0, dataF.instruction}, 64'h9357_9BDF);
      step(); look();
      check("s1_c3_addr", ireq_addr, 64'h8000_0008);
      check("s1_c3_pc", dataF.pc, 64'h8000_0004);
      check("s1_c3_instr", {32'h0, dataF.instruction}, 64'h9357_9BDB);
      repeat (4) step();

      // 3-cycle bus: address held, bubble between fetches
      do_reset(3);
      look();
      check("s2_c1_addr", ireq_addr, 64'h8000_0000);
      step(); look();
      check("s2_c2_addr", ireq_addr, 64'h8000_0000);
      step(); look();
      check("s2_c3_addr", ireq_addr, 64'h8000_0000);
      check("s2_c3_validF", {63'h0, validF}, 64'h0);
      step(); look();
      check("s2_c4_addr", ireq_addr, 64'h8000_0004);
      check("s2_c4_validF", {63'h0, validF}, 64'h1);
      check("s2_c4_pc", dataF.pc, 64'h8000_0000);
      step(); look();
      check("s2_c5_validF", {63'h0, validF}, 64'h0);
      repeat (6) step();

      // stall rising with data_ok: word goes to skid
      do_reset(1);
      step(); stall = 1'b1;
      step(); look();
      check("s3_c3_ireq_valid", {63'h0, ireq_valid}, 64'h0);
      check("s3_c3_validF", {63'h0, validF}, 64'h1);
      check("s3_c3_pc", dataF.pc, 64'h8000_0000);
      step(); look();
      check("s3_c4_ireq_valid", {63'h0, ireq_valid}, 64'h0);
      step(); stall = 1'b0;
      step(); look();
      check("s3_c6_validF", {63'h0, validF}, 64'h1);
      check("s3_c6_pc", dataF.pc, 64'h8000_0004);
      check("s3_c6_addr", ireq_addr, 64'h8000_0008);
      check("s3_c6_ireq_valid", {63'h0, ireq_valid}, 64'h1);
      repeat (3) step();

      // redirect during an outstanding 3-cycle request to 0x8000_0010
      do_reset(3);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(); look();
         if (ireq_valid && ireq_addr == 64'h8000_0010) found = 1'b1;
      end
      check("s4_find_req10", {63'h0, found}, 64'h1);
      step(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      step(); redirect_valid = 1'b0;
      look();
      check("s4_validF_bubble", {63'h0, validF}, 64'h0);
      check("s4_drop_addr", ireq_addr, 64'h8000_0010);
      step(); look();
      check("s4_new_addr", ireq_addr, 64'h8000_0100);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(); look();
         if (validF) found = 1'b1;
      end
      check("s4_target_valid", {63'h0, found}, 64'h1);
      check("s4_target_pc", dataF.pc, 64'h8000_0100);
      repeat (2) step();

      // redirect coincident with data_ok, misaligned target
      do_reset(1);
      step(); redirect_valid = 1'b1; redirect_pc = 64'h8000_0203;
      step(); redirect_valid = 1'b0;
      look();
      check("s5_validF", {63'h0, validF}, 64'h0);
      check("s5_addr", ireq_addr, 64'h8000_0200);
      step(); look();
      check("s5_pc", dataF.pc, 64'h8000_0200);
      check("s5_instr", {32'h0, dataF.instruction}, 64'h9357_99DF);
      repeat (2) step();

      // reset while stalled with the skid full
      do_reset(1);
      step(); stall = 1'b1;
      step(); reset = 1'b1;
      look();
      check("s6_rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
      step(); reset = 1'b0; stall = 1'b0;
      look();
      check("s6_validF", {63'h0, validF}, 64'h0);
      check("s6_skid_valid", {63'h0, dut.skid_valid_q}, 64'h0);
      check("s6_pc", dataF.pc, 64'h8000_0000);
      check("s6_ireq_valid", {63'h0, ireq_valid}, 64'h1);
      check("s6_addr", ireq_addr, 64'h8000_0000);
      repeat (3) step();

      // 2-cycle bus with a stall pattern, masked redirect and PC wrap
      do_reset(2);
      stall_pat = 24'b0000_1100_0011_0111_0010_0110;
      for (int i = 0; i < 24; i++) begin
         stall          = stall_pat[i];
         redirect_valid = (i == 9) || (i == 15);
         redirect_pc    = (i == 9) ? 64'h0000_0000_0000_0FFE : 64'hFFFF_FFFF_FFFF_FFFD;
         step();
      end
      stall = 1'b0; redirect_valid = 1'b0;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
